pwm_bank: RTL and testbench
===========================

Name: pwm_bank

Overview:
- Parametrised multi-channel PWM generator; successor to the single-purpose onboarding top-level logic.
- Driven by a simple register-write port, which the SPI peripheral front-end will later feed.
- One shared prescaler and period counter; per-channel duty registers; per-channel enable mask.
- Duty, period and prescale values are double-buffered: shadow registers are copied to active registers only at a period boundary, so no output glitches.

Parameters:
NUM_CH, 4, number of PWM channels (1..29, and NUM_CH <= WIDTH)
WIDTH, 8, bit width of counter, duty, period, prescale and write data

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
wr_en  input  1  register write strobe, one write per cycle
wr_addr  input  5  register address
wr_data  input  WIDTH  register write data
rd_addr  input  5  register read address
rd_data  output  WIDTH  registered read data (shadow values)
pwm_out  output  NUM_CH  PWM outputs, registered
period_tick  output  1  one-cycle pulse at each period boundary

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Register map:
  - 0..NUM_CH-1: duty shadow, channel n.
  - 0x1D: prescale shadow.
  - 0x1E: top (period) shadow.
  - 0x1F: enable mask, low NUM_CH bits.
  - Writes to any other address are ignored.
- Reset values:
  - All duty shadow/active = 0.
  - Prescale shadow/active = 0.
  - Top shadow/active = all-ones.
  - Enable = 0.
  - pre_cnt = 0, cnt = 0.
  - pwm_out = 0, period_tick = 0, rd_data = 0.
- Prescaler:
  - pre_cnt counts 0..prescale_act, then returns to 0.
  - tick = (pre_cnt == prescale_act).
  - prescale_act = 0 means tick every cycle.
- Period counter:
  - On tick, cnt increments.
  - When tick and cnt == top_act, cnt returns to 0: this is the boundary.
  - Period length = (top_act+1)*(prescale_act+1) cycles.
- Boundary cycle:
  - All duty shadows, top shadow and prescale shadow are copied to active registers.
  - period_tick is asserted on the following cycle, for exactly 1 cycle.
- Simultaneous write and boundary: active registers take the pre-write shadow value; the new value becomes active at the next boundary.
- Output compare:
  - pwm_out[n] is registered (next) = enable[n] & (duty_act[n] > cnt).
  - Output lags the counter by 1 cycle.
  - duty 0 gives constant low.
  - duty > top_act gives constant high.
  - duty is compared at full WIDTH, unsigned.
- Enable mask is not shadowed: clearing bit n forces pwm_out[n] low on the cycle after the write; setting it resumes mid-period with the current compare result.
- Shrinking top below the current cnt has no effect until the boundary, because top is shadowed; cnt never exceeds top_act.
- Read port:
  - rd_data is registered one cycle after rd_addr and returns the shadow/enable value.
  - Enable is returned zero-extended.
  - Unmapped addresses read 0.
- Reset mid-period: all state returns to reset values on the next clock edge; pwm_out goes low the same edge.
- No combinational path from any input to pwm_out or period_tick.

Test Plan:
- Reset, NUM_CH=4, WIDTH=8: hold rst 2 cycles -> pwm_out=0, period_tick=0, rd_data(0x1E)=0xFF; first period_tick 256 cycles after rst release.
- Write duty0=64, enable=0x1 after reset -> after the next boundary, pwm_out[0] is high 64 of every 256 cycles; pwm_out[3:1] stay 0.
- top=9, prescale=1, duty1=5, enable=0x2 -> after the boundary, period = 20 cycles and pwm_out[1] is high 10 cycles; period_tick fires every 20 cycles.
- Write duty0=200 in the same cycle as a boundary -> the following period still uses the old duty; 200 takes effect one period later.
- Edge duties, top=0xFF: duty2=0 gives constant low; top=0x0F with duty2=0xFF gives constant high; clearing enable mid-period drops pwm_out[2] 1 cycle after the write.
- Assert rst mid-period with outputs high -> the next edge gives all outputs 0 and all registers at reset values; write to address 0x10 is ignored and reads back 0.

Source files
------------

// File: rtl/pwm_bank.sv
// rtl/pwm_bank.sv - multi-channel PWM bank with double-buffered duty/period/prescale
module pwm_bank #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [4:0]        wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [4:0]        rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_tick
);

    localparam logic [4:0] ADDR_PRE = 5'h1D;
    localparam logic [4:0] ADDR_TOP = 5'h1E;
    localparam logic [4:0] ADDR_EN  = 5'h1F;

    logic [WIDTH-1:0]  r_duty_sh  [NUM_CH];
    logic [WIDTH-1:0]  r_duty_act [NUM_CH];
    logic [WIDTH-1:0]  r_pre_sh;
    logic [WIDTH-1:0]  r_pre_act;
    logic [WIDTH-1:0]  r_top_sh;
    logic [WIDTH-1:0]  r_top_act;
    logic [WIDTH-1:0]  r_pre_cnt;
    logic [WIDTH-1:0]  r_cnt;
    logic [NUM_CH-1:0] r_en;

    logic              w_tick;
    logic              w_boundary;
    logic [NUM_CH-1:0] w_cmp;
    logic [WIDTH-1:0]  w_rd;

    assign w_tick     = (r_pre_cnt == r_pre_act);
    assign w_boundary = w_tick && (r_cnt == r_top_act);

    always_comb begin
        w_cmp = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            w_cmp[n] = r_en[n] && (r_duty_act[n] > r_cnt);
        end
    end

    // Read mux returns shadow values, not the currently active ones
    always_comb begin
        w_rd = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            if (rd_addr == 5'(n)) begin
                w_rd = r_duty_sh[n];
            end
        end
        if (rd_addr == ADDR_PRE) begin
            w_rd = r_pre_sh;
        end
        if (rd_addr == ADDR_TOP) begin
            w_rd = r_top_sh;
        end
        if (rd_addr == ADDR_EN) begin
            w_rd[NUM_CH-1:0] = r_en;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < NUM_CH; n++) begin
                r_duty_sh[n]  <= '0;
                r_duty_act[n] <= '0;
            end
            r_pre_sh    <= '0;
            r_pre_act   <= '0;
            r_top_sh    <= '1;
            r_top_act   <= '1;
            r_pre_cnt   <= '0;
            r_cnt       <= '0;
            r_en        <= '0;
            pwm_out     <= '0;
            period_tick <= 1'b0;
            rd_data     <= '0;
        end else begin
            if (wr_en) begin
                for (int n = 0; n < NUM_CH; n++) begin
                    if (wr_addr == 5'(n)) begin
                        r_duty_sh[n] <= wr_data;
                    end
                end
                if (wr_addr == ADDR_PRE) begin
                    r_pre_sh <= wr_data;
                end
                if (wr_addr == ADDR_TOP) begin
                    r_top_sh <= wr_data;
                end
                if (wr_addr == ADDR_EN) begin
                    r_en <= wr_data[NUM_CH-1:0];
                end
            end

            // Nonblocking reads of the shadows give pre-write values on a colliding write
            if (w_boundary) begin
                for (int n = 0; n < NUM_CH; n++) begin
                    r_duty_act[n] <= r_duty_sh[n];
                end
                r_pre_act <= r_pre_sh;
                r_top_act <= r_top_sh;
            end

            if (w_tick) begin
                r_pre_cnt <= '0;
                r_cnt     <= (r_cnt == r_top_act) ? '0 : r_cnt + WIDTH'(1);
            end else begin
                r_pre_cnt <= r_pre_cnt + WIDTH'(1);
            end

            pwm_out     <= w_cmp;
            period_tick <= w_boundary;
            rd_data     <= w_rd;
        end
    end

endmodule

// File: tb/tb_pwm_bank.sv
// tb/tb_pwm_bank.sv - directed self-checking bench for pwm_bank
module tb_pwm_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [4:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic [4:0] rd_addr = '0;
    logic [7:0] rd_data;
    logic [3:0] pwm_out;
    logic       period_tick;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pwm_bank #(.NUM_CH(4), .WIDTH(8)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .pwm_out(pwm_out), .period_tick(period_tick)
    );

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [7:0] d);
        @(negedge clk);
        rd_addr = a;
        @(negedge clk);
        d = rd_data;
    endtask

    task automatic wait_tick(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (period_tick) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic measure(input int ch, input int n, output int hi, output int ticks,
                           output logic [3:0] seen);
        hi = 0; ticks = 0; seen = '0;
        repeat (n) begin
            @(negedge clk);
            if (pwm_out[ch]) hi++;
            if (period_tick) ticks++;
            seen = seen | pwm_out;
        end
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1; rd_addr = 5'h1E;
        repeat (2) @(negedge clk);
        total++; if (pwm_out !== 4'h0) begin bad++; $display("FAIL reset_pwm got=%h exp=0", pwm_out); end
        total++; if (period_tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b exp=0", period_tick); end
        total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL reset_rd got=%h exp=00", rd_data); end
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            n++;
            if (period_tick) break;
        end
        total++; if (n !== 256) begin bad++; $display("FAIL first_tick got=%0d exp=256", n); end
        total++; if (rd_data !== 8'hFF) begin bad++; $display("FAIL reset_top_rd got=%h exp=ff", rd_data); end
    endtask

    task automatic test_duty_basic();
        bit ok; int hi, tk; logic [3:0] seen;
        wr(5'h00, 8'd64);
        wr(5'h1F, 8'h01);
        wait_tick(300, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL basic_tick_timeout got=%b exp=1", ok); end
        measure(0, 256, hi, tk, seen);
        total++; if (hi !== 64) begin bad++; $display("FAIL basic_high got=%0d exp=64", hi); end
        total++; if (tk !== 1) begin bad++; $display("FAIL basic_ticks got=%0d exp=1", tk); end
        total++; if (seen[3:1] !== 3'b000) begin bad++; $display("FAIL basic_others got=%b exp=000", seen[3:1]); end
    endtask

    task automatic test_prescale();
        bit ok; int hi, tk; logic [3:0] seen;
        wr(5'h1E, 8'd9);
        wr(5'h1D, 8'd1);
        wr(5'h01, 8'd5);
        wr(5'h1F, 8'h02);
        wait_tick(300, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL pre_tick_timeout got=%b exp=1", ok); end
        measure(1, 40, hi, tk, seen);
        total++; if (hi !== 20) begin bad++; $display("FAIL pre_high got=%0d exp=20", hi); end
        total++; if (tk !== 2) begin bad++; $display("FAIL pre_ticks got=%0d exp=2", tk); end
        total++; if (seen[0] !== 1'b0) begin bad++; $display("FAIL pre_ch0_off got=%b exp=0", seen[0]); end
    endtask

    task automatic test_back_to_back();
        bit ok; int hi, tk; logic [3:0] seen; logic [7:0] d;
        wr(5'h00, 8'd3);
        wr(5'h1F, 8'h03);
        wait_tick(40, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL b2b_tick_timeout got=%b exp=1", ok); end
        repeat (19) @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'h00; wr_data = 8'd200;
        @(negedge clk);
        wr_en = 1'b0;
        total++; if (period_tick !== 1'b1) begin bad++; $display("FAIL b2b_aligned got=%b exp=1", period_tick); end
        measure(0, 20, hi, tk, seen);
        total++; if (hi !== 6) begin bad++; $display("FAIL b2b_old_duty got=%0d exp=6", hi); end
        measure(0, 20, hi, tk, seen);
        total++; if (hi !== 20) begin bad++; $display("FAIL b2b_new_duty got=%0d exp=20", hi); end
        rd(5'h00, d);
        total++; if (d !== 8'd200) begin bad++; $display("FAIL b2b_readback got=%0d exp=200", d); end
    endtask

    task automatic test_edge_duty();
        bit ok; int hi, tk; logic [3:0] seen;
        wr(5'h1E, 8'hFF);
        wr(5'h1D, 8'h00);
        wr(5'h02, 8'h00);
        wr(5'h1F, 8'h04);
        wait_tick(40, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL edge_tick_timeout got=%b exp=1", ok); end
        measure(2, 256, hi, tk, seen);
        total++; if (hi !== 0) begin bad++; $display("FAIL edge_duty0 got=%0d exp=0", hi); end
        total++; if (tk !== 1) begin bad++; $display("FAIL edge_ticks got=%0d exp=1", tk); end
        wr(5'h1E, 8'h0F);
        wr(5'h02, 8'hFF);
        wait_tick(300, ok);
        measure(2, 16, hi, tk, seen);
        total++; if (hi !== 16) begin bad++; $display("FAIL edge_duty_max got=%0d exp=16", hi); end
        repeat (3) @(negedge clk);
        total++; if (pwm_out[2] !== 1'b1) begin bad++; $display("FAIL edge_pre_clear got=%b exp=1", pwm_out[2]); end
        wr_en = 1'b1; wr_addr = 5'h1F; wr_data = 8'h00;
        @(negedge clk);
        wr_en = 1'b0;
        @(negedge clk);
        total++; if (pwm_out[2] !== 1'b0) begin bad++; $display("FAIL edge_en_clear got=%b exp=0", pwm_out[2]); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        wr(5'h1F, 8'h04);
        repeat (3) @(negedge clk);
        total++; if (pwm_out[2] !== 1'b1) begin bad++; $display("FAIL mid_high got=%b exp=1", pwm_out[2]); end
        rst = 1'b1;
        @(negedge clk);
        total++; if (pwm_out !== 4'h0) begin bad++; $display("FAIL mid_pwm got=%h exp=0", pwm_out); end
        total++; if (period_tick !== 1'b0) begin bad++; $display("FAIL mid_tick got=%b exp=0", period_tick); end
        rst = 1'b0;
        rd(5'h1E, d);
        total++; if (d !== 8'hFF) begin bad++; $display("FAIL mid_top got=%h exp=ff", d); end
        rd(5'h1D, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL mid_pre got=%h exp=00", d); end
        rd(5'h02, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL mid_duty2 got=%h exp=00", d); end
        rd(5'h1F, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL mid_en got=%h exp=00", d); end
        wr(5'h10, 8'h55);
        rd(5'h10, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL unmapped got=%h exp=00", d); end
        rd(5'h1D, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL unmapped_alias got=%h exp=00", d); end
    endtask

    initial begin
        test_reset();
        test_duty_basic();
        test_prescale();
        test_back_to_back();
        test_edge_duty();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
